// File: rtl/delay_scheduler_if.sv
// Request/grant bundle between timed-wait clients and the shared delay scheduler.
interface delay_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DLY_W = 8
) ();
  logic                   enable;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*DLY_W-1:0] delay_in;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [DLY_W-1:0]       remaining;

  modport master (
    output enable, req, delay_in,
    input  grant, done, busy, remaining
  );

  modport slave (
    input  enable, req, delay_in,
    output grant, done, busy, remaining
  );
endinterface

// File: rtl/delay_scheduler.sv
// Round-robin shared prescaled countdown timer for N_REQ requesters.
// Optional DELAY_SCHED_ABORT_EN: owner dropping req during RUN aborts without a done pulse.
module delay_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned DLY_W    = 8
) (
  input logic              clk,
  input logic              reset,
  delay_scheduler_if.slave bus
);
  localparam int unsigned      IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DLY_W-1:0]   rem_q, rem_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   sel_idx, cand;
  logic               sel_found;
  logic [DLY_W-1:0]   sel_dly;
  logic               tick_wrap;
  logic               abort;

  // First asserted request searching upward from the slot after the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % int'(N_REQ));
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_dly = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (sel_idx == IDX_W'(i)) sel_dly = bus.delay_in[i*DLY_W +: DLY_W];
    end
  end

  assign tick_wrap = bus.enable && (pre_q == PRE_MAX);

`ifdef DELAY_SCHED_ABORT_EN
  assign abort = (state_q == StRun) && !bus.req[owner_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    unique case (state_q)
      StIdle: begin
        pre_d = '0;
        rem_d = '0;
        if (bus.enable && sel_found) begin
          state_d = StRun;
          owner_d = sel_idx;
          rem_d   = sel_dly;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          rem_d   = '0;
          pre_d   = '0;
          ptr_d   = owner_q;
        end else if (rem_q == '0) begin
          // Zero delay expires on the first RUN edge without spending a tick.
          state_d = StDone;
        end else if (tick_wrap) begin
          pre_d = '0;
          rem_d = rem_q - 1'b1;
          if (rem_q == DLY_W'(1)) state_d = StDone;
        end else if (bus.enable) begin
          pre_d = pre_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = owner_q;
        rem_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      rem_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.grant     = (state_q == StRun)  ? (ONE_HOT << owner_q) : '0;
  assign bus.done      = (state_q == StDone) ? (ONE_HOT << owner_q) : '0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.remaining = rem_q;
endmodule

// File: tb/tb_delay_scheduler.sv
// Scoreboard bench for delay_scheduler: a schedule-level model predicts done events
// and per-cycle grant/busy/remaining; a negedge monitor compares.
module tb_delay_scheduler;
  localparam int N    = 4;
  localparam int TD   = 4;
  localparam int DW   = 8;
  localparam int MAXC = 16384;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  delay_scheduler_if #(.N_REQ(N), .DLY_W(DW)) bus ();

  delay_scheduler #(.N_REQ(N), .TICK_DIV(TD), .DLY_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {int idx; int at;} exp_t;
  exp_t sb[$];
  exp_t mon_item;

  bit [N-1:0] exp_grant [MAXC];
  bit         exp_busy  [MAXC];
  int         exp_rem   [MAXC];
  bit         en_tl     [MAXC];
  bit         chk_en = 1'b0;

  int txn_cnt [N];
  int txn_dly [N];
  int last_done [N];
  int model_ptr = N - 1;
  int t_end;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: pop the scoreboard on every done pulse; compare the per-cycle timeline.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", int'(bus.done), 0);
        end else begin
          mon_item = sb.pop_front();
          check("done_owner", int'(bus.done), 1 << mon_item.idx);
          check("done_cycle", cyc, mon_item.at);
        end
      end
      if (chk_en && cyc < MAXC) begin
        check("grant", int'(bus.grant), int'(exp_grant[cyc]));
        check("busy", int'(bus.busy), int'(exp_busy[cyc]));
        check("remaining", int'(bus.remaining), exp_rem[cyc]);
      end
    end
  end

  task automatic guard(input int c);
    if (c >= MAXC - 4) begin
      $display("FAIL model_range: cycle %0d exceeds table of %0d", c, MAXC);
      $fatal(1);
    end
  endtask

  // Schedule model: services requests in round-robin order, each granted the cycle
  // after an enabled idle cycle and lasting D*TD enabled cycles (one cycle if D=0).
  task automatic plan(input int t0);
    int left [N];
    int c, sel, d, e, got, w, ne, more, j;
    for (int i = 0; i < N; i++) begin
      left[i]      = txn_cnt[i];
      last_done[i] = -1;
    end
    c = t0;
    forever begin
      more = 0;
      for (int i = 0; i < N; i++) more += left[i];
      if (more == 0) break;
      while (!en_tl[c]) begin
        c++;
        guard(c);
      end
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        j = (model_ptr + k) % N;
        if (sel < 0 && left[j] > 0) sel = j;
      end
      d = txn_dly[sel];
      if (d == 0) begin
        e = c + 1;
      end else begin
        got = 0;
        e   = c;
        while (got < d * TD) begin
          e++;
          guard(e);
          if (en_tl[e]) got++;
        end
      end
      w  = 0;
      ne = 0;
      for (int x = c + 1; x <= e; x++) begin
        exp_grant[x] = N'(1) << sel;
        exp_busy[x]  = 1'b1;
        exp_rem[x]   = d - w;
        if (en_tl[x]) begin
          ne++;
          if (ne % TD == 0) w++;
        end
      end
      exp_busy[e+1] = 1'b1;
      sb.push_back('{sel, e + 1});
      last_done[sel] = e + 1;
      left[sel]--;
      model_ptr = sel;
      c = e + 2;
    end
    t_end = c;
  endtask

  task automatic fill_en(input int t0, input bit all_on);
    for (int x = t0; x < MAXC && x <= t0 + 1500; x++)
      en_tl[x] = all_on ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // Requesters hold req until their last predicted done, then release it.
  task automatic drive(input int t0);
    for (int x = t0; x <= t_end + 2; x++) begin
      bus.enable = en_tl[x];
      for (int i = 0; i < N; i++) begin
        bus.req[i] = (txn_cnt[i] > 0) && (x <= last_done[i]);
        bus.delay_in[i*DW +: DW] = (txn_cnt[i] > 0) ? DW'(txn_dly[i]) : DW'($urandom);
      end
      @(negedge clk);
    end
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_txn(input int t0);
    plan(t0);
    drive(t0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    bus.enable   = 1'b0;
    bus.req      = '0;
    bus.delay_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    chk_en = 1'b1;

    // Fairness: all four requesters, zero delays, requester 0 asks twice.
    t0 = cyc; fill_en(t0, 1'b1);
    txn_cnt = '{2, 1, 1, 1}; txn_dly = '{0, 0, 0, 0};
    run_txn(t0);

    // Single request, delay 3.
    t0 = cyc; fill_en(t0, 1'b1);
    txn_cnt = '{1, 0, 0, 0}; txn_dly = '{3, 0, 0, 0};
    run_txn(t0);

    // Simultaneous requests 0 and 2, delay 1 each.
    t0 = cyc; fill_en(t0, 1'b1);
    txn_cnt = '{1, 0, 1, 0}; txn_dly = '{1, 0, 1, 0};
    run_txn(t0);

    // Enable low for 5 cycles during RUN.
    t0 = cyc; fill_en(t0, 1'b1);
    for (int x = t0 + 3; x <= t0 + 7; x++) en_tl[x] = 1'b0;
    txn_cnt = '{1, 0, 0, 0}; txn_dly = '{2, 0, 0, 0};
    run_txn(t0);

    // Enable low in IDLE with a request pending.
    t0 = cyc; fill_en(t0, 1'b1);
    for (int x = t0; x <= t0 + 2; x++) en_tl[x] = 1'b0;
    txn_cnt = '{0, 0, 0, 1}; txn_dly = '{0, 0, 0, 2};
    run_txn(t0);

    // Reset in the middle of a run.
    chk_en       = 1'b0;
    bus.enable   = 1'b1;
    bus.req      = 4'b0001;
    bus.delay_in = {8'd0, 8'd0, 8'd0, 8'd5};
    repeat (6) @(negedge clk);
    check("busy_before_reset", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", int'(bus.grant), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_remaining", int'(bus.remaining), 0);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_ptr = N - 1;
    chk_en    = 1'b1;

    t0 = cyc; fill_en(t0, 1'b1);
    txn_cnt = '{0, 1, 0, 0}; txn_dly = '{0, 2, 0, 0};
    run_txn(t0);

`ifdef DELAY_SCHED_ABORT_EN
    // Owner 0 drops req mid-run: no done for it, requester 1 granted after one IDLE cycle.
    chk_en       = 1'b0;
    t0           = cyc;
    bus.enable   = 1'b1;
    bus.req      = 4'b0011;
    bus.delay_in = {8'd0, 8'd0, 8'd1, 8'd5};
    @(negedge clk);
    check("abort_grant_owner", int'(bus.grant), 1);
    repeat (5) @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    check("abort_grant_clear", int'(bus.grant), 0);
    check("abort_busy_clear", int'(bus.busy), 0);
    check("abort_remaining_clear", int'(bus.remaining), 0);
    @(negedge clk);
    check("abort_next_grant", int'(bus.grant), 2);
    sb.push_back('{1, t0 + 12});
    repeat (4) @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("abort_sb_drained", sb.size(), 0);
    sb.delete();
    model_ptr = 1;
    chk_en    = 1'b1;
`endif

    // Randomised transactions with random enable gaps.
    for (int n = 0; n < 40; n++) begin
      t0 = cyc; fill_en(t0, 1'b0);
      for (int i = 0; i < N; i++) begin
        txn_cnt[i] = $urandom_range(0, 2);
        txn_dly[i] = $urandom_range(0, 5);
      end
      if (txn_cnt[0] + txn_cnt[1] + txn_cnt[2] + txn_cnt[3] == 0)
        txn_cnt[$urandom_range(0, N - 1)] = 1;
      run_txn(t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Shares one prescaled countdown timer among N_REQ requesters.
- Each requester raises req with a tick count. A round-robin arbiter grants the timer to one requester at a time and loads that requester's delay. It pulses that requester's done bit when the delay expires.
- Sits between the FSM modules that need timed waits (debounce, display blanking, sequencing) and the free-running clock.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- TICK_DIV, 100: clk cycles per timer tick (>=1).
- DLY_W, 8: width of each delay value, in ticks.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global run enable. Low freezes the prescaler and blocks new grants.
- req  input  N_REQ  per-requester level request.
- delay_in  input  N_REQ*DLY_W  flattened delays. Requester i uses bits [i*DLY_W +: DLY_W]. Sampled only at grant.
- grant  output  N_REQ  one-hot, registered. High for the whole RUN phase of the owner.
- done  output  N_REQ  one-hot one-cycle pulse to the owner at expiry.
- busy  output  1  high in RUN and DONE.
- remaining  output  DLY_W  ticks left for the current owner. 0 when idle.

Behaviour:
- Reset (async): state=IDLE, grant=0, done=0, busy=0, remaining=0, prescaler=0, rr pointer=N_REQ-1, so requester 0 has first priority.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If enable=1 and req!=0, select the first asserted req searching upward from pointer+1 (mod N_REQ).
  - On the next edge: grant[sel]=1, remaining=delay_in[sel], prescaler=0, state=RUN, busy=1.
  - If enable=0, hold IDLE regardless of req.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 on cycles with enable=1 and wraps to 0. It holds when enable=0.
  - On each wrap, remaining decrements.
  - Move to DONE on the edge where remaining is 1 and the prescaler wraps.
  - If remaining was loaded as 0, move to DONE on the first RUN edge. No tick is spent.
- DONE (exactly one cycle):
  - done[owner]=1, grant=0, remaining=0, pointer=owner.
  - Next state is IDLE; done returns to 0.
- Latency: with req sampled in IDLE at cycle 0 and enable held high:
  - grant is high from cycle 1.
  - done pulses at cycle 1 + D*TICK_DIV for D>=1, and at cycle 2 for D=0.
  - Each enable-low cycle during RUN adds exactly one cycle.
- Back-to-back: at least one IDLE cycle separates consecutive grants, so the minimum service period is D*TICK_DIV+2 cycles.
- Request handling:
  - req is level-sensitive. A requester still high after its done competes again, with lowest priority.
  - Changes to req or delay_in of the owner during RUN are ignored (without the optional feature).
- Arithmetic: remaining never underflows. Decrement only when nonzero. Prescaler width is $clog2(TICK_DIV) with a minimum of 1 bit.
- Reset mid-operation: all outputs clear immediately (async). No done is issued for the interrupted request.

Optional Feature:
- Macro: DELAY_SCHED_ABORT_EN.
- Defined:
  - If the owner's req drops to 0 during RUN, the next edge goes directly to IDLE.
  - grant and remaining clear, no done pulse, pointer=owner (round-robin still advances).
  - A drop in the same cycle as the final tick wrap counts as an abort.
- Not defined: owner req is ignored during RUN, as stated above.

Test Plan:
- Common setup: TICK_DIV=4, N_REQ=4, DLY_W=8, enable=1 unless stated.
- 1 (single request): req=0001, delay0=3 at cycle 0 -> grant=0001 from cycle 1; remaining 3,2,1; done=0001 only at cycle 13; busy low at cycle 14.
- 2 (simultaneous): req=0101 held, both delays=1 -> grant 0001 (done cycle 5), IDLE cycle 6, grant 0100 from cycle 7, done=0100 at cycle 11.
- 3 (fairness): req=1111 held, all delays=0 -> grant order 0,1,2,3,0. Each done pulse is exactly 3 cycles apart.
- 4 (enable freeze): delay0=2, enable low for 5 cycles during RUN -> done at cycle 14 instead of 9; remaining unchanged while low; no grant while enable low in IDLE.
- 5 (reset mid-run): reset asserted mid-RUN -> grant, done, busy and remaining are 0 before the next clk edge. After release, req1 alone is granted first.
- 6 (abort, DELAY_SCHED_ABORT_EN defined): delay0=5, req0 dropped at cycle 6 -> grant=0 at cycle 7, no done pulse ever; pending req1 granted at cycle 8.
